// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter sharing the register file write port
// Optional build macro RF_ZERO_DROP_EN: accepted writes to register 0 never raise rf_we.
module rf_write_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*5-1:0]      req_dst,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      stall,
    output logic                      rf_we,
    output logic [4:0]                rf_dst,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [2:0]                grant_id,
    output logic [CNT_W-1:0]          contention_cnt
);

    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        gnt;
    logic              xfer;
    logic              we_d, we_q;
    logic [4:0]        dst_q, sel_dst;
    logic [DATA_W-1:0] data_q, sel_data;
    logic [2:0]        gid_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    int                off, best_off;

    // Distance from ptr decides priority; the smallest distance among valid requesters wins.
    always_comb begin
        xfer      = 1'b0;
        gnt       = 3'd0;
        off       = 0;
        best_off  = NUM_REQ;
        sel_dst   = '0;
        sel_data  = '0;
        req_ready = '0;
        if (!stall && !rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                off = i - int'(ptr_q);
                if (off < 0) off = off + NUM_REQ;
                if (req_valid[i] && off < best_off) begin
                    best_off = off;
                    gnt      = 3'(i);
                    xfer     = 1'b1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && gnt == 3'(i)) begin
                    req_ready[i] = 1'b1;
                    sel_dst      = req_dst[5*i +: 5];
                    sel_data     = req_data[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (int'(gnt) == NUM_REQ - 1) ? 3'd0 : gnt + 3'd1;
`ifdef RF_ZERO_DROP_EN
        we_d = xfer && (sel_dst != 5'd0);
`else
        we_d = xfer;
`endif
        cnt_d = cnt_q;
        if (!stall && $countones(req_valid) >= 2 && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= 3'd0;
            we_q   <= 1'b0;
            dst_q  <= '0;
            data_q <= '0;
            gid_q  <= 3'd0;
            cnt_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= we_d;
            cnt_q <= cnt_d;
            if (xfer) begin
                dst_q  <= sel_dst;
                data_q <= sel_data;
                gid_q  <= gnt;
            end
        end
    end

    assign rf_we          = we_q;
    assign rf_dst         = dst_q;
    assign rf_wdata       = data_q;
    assign grant_id       = gid_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed vector bench for rf_write_arbiter
module tb_rf_write_arbiter;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 4;

`ifdef RF_ZERO_DROP_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    localparam logic [14:0] SD = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] SX = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [2:0]        req_valid;
    logic [14:0]       req_dst;
    logic [95:0]       req_data;
    logic [2:0]        req_ready;
    logic              rf_we;
    logic [4:0]        rf_dst;
    logic [31:0]       rf_wdata;
    logic [2:0]        grant_id;
    logic [CNT_W-1:0]  contention_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dst(req_dst),
        .req_data(req_data), .req_ready(req_ready), .stall(stall),
        .rf_we(rf_we), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
        .grant_id(grant_id), .contention_cnt(contention_cnt)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  valid;
        logic [14:0] dst;
        logic [95:0] data;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [4:0]  e_dst;
        logic [31:0] e_data;
        logic [2:0]  e_gid;
        logic [3:0]  e_cnt;
        logic        chkd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic s, logic [2:0] v, logic [14:0] d, logic [95:0] x,
                                logic [2:0] er, logic ew, logic [4:0] ed, logic [31:0] ex,
                                logic [2:0] eg, logic [3:0] ec, logic cd);
        vec_t t;
        t.rst = r; t.stall = s; t.valid = v; t.dst = d; t.data = x;
        t.e_ready = er; t.e_we = ew; t.e_dst = ed; t.e_data = ex;
        t.e_gid = eg; t.e_cnt = ec; t.chkd = cd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [2:0] v,
                         input logic [14:0] d, input logic [95:0] x);
        @(negedge clk);
        rst = r; stall = s; req_valid = v; req_dst = d; req_data = x;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; req_valid = '0; req_dst = '0; req_data = '0;

        // reset then idle
        vq.push_back(mk(1, 0, 3'b000, SD, SX, 3'b000, 0, 5'd0, 32'h0, 3'd0, 4'd0, 1));
        vq.push_back(mk(1, 0, 3'b000, SD, SX, 3'b000, 0, 5'd0, 32'h0, 3'd0, 4'd0, 1));
        vq.push_back(mk(0, 0, 3'b000, SD, SX, 3'b000, 0, 5'd0, 32'h0, 3'd0, 4'd0, 1));
        // single requester 1, then idle holds rf_dst/rf_wdata/grant_id
        vq.push_back(mk(0, 0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                        3'b010, 1, 5'd5, 32'hDEADBEEF, 3'd1, 4'd0, 1));
        vq.push_back(mk(0, 0, 3'b000, SD, SX, 3'b000, 0, 5'd5, 32'hDEADBEEF, 3'd1, 4'd0, 1));
        // reset with all valid: no grant, then round robin 0,1,2,0,1,2
        vq.push_back(mk(1, 0, 3'b111, SD, SX, 3'b000, 0, 5'd0, 32'h0, 3'd0, 4'd0, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b001, 1, 5'd1, 32'hAAAA0000, 3'd0, 4'd1, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b010, 1, 5'd2, 32'hBBBB0001, 3'd1, 4'd2, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b100, 1, 5'd3, 32'hCCCC0002, 3'd2, 4'd3, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b001, 1, 5'd1, 32'hAAAA0000, 3'd0, 4'd4, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b010, 1, 5'd2, 32'hBBBB0001, 3'd1, 4'd5, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b100, 1, 5'd3, 32'hCCCC0002, 3'd2, 4'd6, 1));
        // stall 3 cycles: nothing moves, then resume at ptr=0
        vq.push_back(mk(0, 1, 3'b111, SD, SX, 3'b000, 0, 5'd3, 32'hCCCC0002, 3'd2, 4'd6, 1));
        vq.push_back(mk(0, 1, 3'b111, SD, SX, 3'b000, 0, 5'd3, 32'hCCCC0002, 3'd2, 4'd6, 1));
        vq.push_back(mk(0, 1, 3'b111, SD, SX, 3'b000, 0, 5'd3, 32'hCCCC0002, 3'd2, 4'd6, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b001, 1, 5'd1, 32'hAAAA0000, 3'd0, 4'd7, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b010, 1, 5'd2, 32'hBBBB0001, 3'd1, 4'd8, 1));
        vq.push_back(mk(0, 1, 3'b111, SD, SX, 3'b000, 0, 5'd2, 32'hBBBB0001, 3'd1, 4'd8, 1));
        // wrap-around search from ptr=2, then two-valid contention
        vq.push_back(mk(0, 0, 3'b001, SD, SX, 3'b001, 1, 5'd1, 32'hAAAA0000, 3'd0, 4'd8, 1));
        vq.push_back(mk(0, 0, 3'b101, SD, SX, 3'b100, 1, 5'd3, 32'hCCCC0002, 3'd2, 4'd9, 1));
        vq.push_back(mk(0, 0, 3'b001, SD, SX, 3'b001, 1, 5'd1, 32'hAAAA0000, 3'd0, 4'd9, 1));
        // reset mid-stream with ptr=1: write discarded, ptr back to 0
        vq.push_back(mk(1, 0, 3'b111, SD, SX, 3'b000, 0, 5'd0, 32'h0, 3'd0, 4'd0, 1));
        vq.push_back(mk(0, 0, 3'b111, SD, SX, 3'b001, 1, 5'd1, 32'hAAAA0000, 3'd0, 4'd1, 1));
        // dst=0 write from requester 0 (ptr=1 wraps to 0)
        vq.push_back(mk(0, 0, 3'b001, {5'd3, 5'd2, 5'd0}, {64'h0, 32'h12345678},
                        3'b001, !ZD, 5'd0, 32'h12345678, 3'd0, 4'd1, !ZD));

        foreach (vq[n]) begin
            drive(vq[n].rst, vq[n].stall, vq[n].valid, vq[n].dst, vq[n].data);
            chk($sformatf("v%0d ready", n), 32'(req_ready), 32'(vq[n].e_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rf_we", n), 32'(rf_we), 32'(vq[n].e_we));
            chk($sformatf("v%0d grant_id", n), 32'(grant_id), 32'(vq[n].e_gid));
            chk($sformatf("v%0d cnt", n), 32'(contention_cnt), 32'(vq[n].e_cnt));
            if (vq[n].chkd) begin
                chk($sformatf("v%0d rf_dst", n), 32'(rf_dst), 32'(vq[n].e_dst));
                chk($sformatf("v%0d rf_wdata", n), rf_wdata, vq[n].e_data);
            end
        end

        // sustained contention from ptr=1: rotating grants, counter saturates at 15
        for (int k = 0; k < 20; k++) begin
            automatic int g = (1 + k) % NUM_REQ;
            automatic int c = (2 + k > 15) ? 15 : 2 + k;
            drive(1'b0, 1'b0, 3'b111, SD, SX);
            chk($sformatf("sat%0d ready", k), 32'(req_ready), 32'(3'b001 << g));
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d rf_we", k), 32'(rf_we), 32'd1);
            chk($sformatf("sat%0d grant_id", k), 32'(grant_id), 32'(g));
            chk($sformatf("sat%0d rf_dst", k), 32'(rf_dst), 32'(g + 1));
            chk($sformatf("sat%0d cnt", k), 32'(contention_cnt), 32'(c));
        end

        // stall while saturated: counter stays at max, no write
        drive(1'b0, 1'b1, 3'b111, SD, SX);
        chk("stall_sat ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("stall_sat rf_we", 32'(rf_we), 32'd0);
        chk("stall_sat cnt", 32'(contention_cnt), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
